i2s_tx_feeder: RTL

Clock and frame master for the I2S transmit path. It divides the system clock into SCLK and LRCK for `i2s_tx`. It accepts stereo samples from the DSP core over a valid/ready handshake, holds one of them in a pending buffer, and presents them to `i2s_tx` as stable parallel left/right words. It also detects and counts underruns, meaning frames for which the DSP core supplied no sample in time.

---
 rtl/i2s_tx_feeder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_feeder.sv
// i2s_tx_feeder: clock and frame master for the I2S transmit path.
//
// Divides clk_in into sclk_out/lrck_out for i2s_tx. Takes stereo samples over a
// valid/ready handshake into a single pending entry. Once per frame, at the
// falling SCLK edge in the middle of the right word, it moves that entry to the
// stable parallel outputs. If no sample is pending at that point, it zeroes the
// words and counts an underrun.
//
// Ports:
//   clk_in        system clock (only clock)
//   rst_n_in      asynchronous active-low reset
//   enable_in     run the SCLK/LRCK generator; low parks it at frame start
//   s_valid_in    sample valid
//   s_ready_out   pending entry empty (registered)
//   s_ldata_in    left sample
//   s_rdata_in    right sample
//   sclk_out      serial bit clock to i2s_tx
//   lrck_out      word select, 0 = left, 1 = right
//   pldata_out    left word to i2s_tx
//   prdata_out    right word to i2s_tx
//   underrun_out  one-cycle pulse per underrun
//   ucount_out    saturating underrun count
module i2s_tx_feeder #(
  parameter int unsigned PDATA_WIDTH = 32,
  parameter int unsigned SCLK_HALF   = 4,
  parameter int unsigned UCNT_WIDTH  = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic                   s_valid_in,
  output logic                   s_ready_out,
  input  logic [PDATA_WIDTH-1:0] s_ldata_in,
  input  logic [PDATA_WIDTH-1:0] s_rdata_in,
  output logic                   sclk_out,
  output logic                   lrck_out,
  output logic [PDATA_WIDTH-1:0] pldata_out,
  output logic [PDATA_WIDTH-1:0] prdata_out,
  output logic                   underrun_out,
  output logic [UCNT_WIDTH-1:0]  ucount_out
);

  localparam int unsigned DivW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned BitW = $clog2(2 * PDATA_WIDTH);

  localparam logic [DivW-1:0] DivLast   = DivW'(SCLK_HALF - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(2 * PDATA_WIDTH - 1);
  localparam logic [BitW-1:0] BitRight  = BitW'(PDATA_WIDTH);
  localparam logic [BitW-1:0] BitUpdate = BitW'(PDATA_WIDTH + PDATA_WIDTH / 2);

  logic [DivW-1:0]        div_cnt_q, div_cnt_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BitW-1:0]        bit_nxt;
  logic                   sclk_q, sclk_d;
  logic                   lrck_q, lrck_d;
  logic                   full_q, full_d;
  logic                   s_ready_q;
  logic [PDATA_WIDTH-1:0] pend_l_q, pend_l_d;
  logic [PDATA_WIDTH-1:0] pend_r_q, pend_r_d;
  logic [PDATA_WIDTH-1:0] pldata_q, pldata_d;
  logic [PDATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                   underrun_q, underrun_d;
  logic [UCNT_WIDTH-1:0]  ucount_q, ucount_d;

  logic div_wrap, fall, update, accept;

  always_comb begin
    div_wrap = enable_in && (div_cnt_q == DivLast);
    fall     = div_wrap && sclk_q;
    bit_nxt  = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
    // Mid right word: i2s_tx has latched the right word and not yet the next left.
    update   = fall && (bit_nxt == BitUpdate);
    accept   = s_valid_in && s_ready_q;

    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    lrck_d     = lrck_q;
    full_d     = full_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    pldata_d   = pldata_q;
    prdata_d   = prdata_q;
    underrun_d = 1'b0;
    ucount_d   = ucount_q;

    if (!enable_in) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      sclk_d    = 1'b0;
      lrck_d    = 1'b0;
    end else begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
      if (div_wrap) begin
        sclk_d = ~sclk_q;
      end
      if (fall) begin
        bit_cnt_d = bit_nxt;
        if (bit_nxt == BitRight) begin
          lrck_d = 1'b1;
        end else if (bit_nxt == '0) begin
          lrck_d = 1'b0;
        end
      end
    end

    if (update) begin
      full_d = 1'b0;
      if (full_q) begin
        pldata_d = pend_l_q;
        prdata_d = pend_r_q;
      end else begin
        pldata_d   = '0;
        prdata_d   = '0;
        underrun_d = 1'b1;
        if (ucount_q != '1) begin
          ucount_d = ucount_q + 1'b1;
        end
      end
    end

    // An accept in the update cycle always lands in the pending entry: no bypass.
    if (accept) begin
      full_d   = 1'b1;
      pend_l_d = s_ldata_in;
      pend_r_d = s_rdata_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      full_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      pldata_q   <= '0;
      prdata_q   <= '0;
      underrun_q <= 1'b0;
      ucount_q   <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      lrck_q     <= lrck_d;
      full_q     <= full_d;
      // Ready lags the buffer flag by one cycle; sources pulse valid for one handshake.
      s_ready_q  <= ~full_q;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      pldata_q   <= pldata_d;
      prdata_q   <= prdata_d;
      underrun_q <= underrun_d;
      ucount_q   <= ucount_d;
    end
  end

  assign s_ready_out  = s_ready_q;
  assign sclk_out     = sclk_q;
  assign lrck_out     = lrck_q;
  assign pldata_out   = pldata_q;
  assign prdata_out   = prdata_q;
  assign underrun_out = underrun_q;
  assign ucount_out   = ucount_q;

endmodule
